// File: rtl/serial_tx.sv
// serial_tx: parallel-to-serial transmitter.
// Frames a DATA_W-bit word as start bit, data LSB first, optional even
// parity, stop bit. Each bit is held CLKS_PER_BIT clock cycles on a
// registered line that idles high.
// Build option: define SERIAL_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              out,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] shifted;
    logic              out_q, out_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              tick;
`ifdef SERIAL_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    // Next-state, next-output and datapath computation for the framing FSM.
    always_comb begin
        tick     = (cnt_q == CNT_MAX);
        shifted  = shreg_q >> 1;
        state_d  = state_q;
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        out_d    = out_q;
        ready_d  = ready_q;
        done_d   = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                out_d = 1'b1;
                if (valid && ready_q) begin
                    shreg_d  = data_in;
`ifdef SERIAL_TX_PARITY_EN
                    parity_d = ^data_in;
`endif
                    state_d  = S_START;
                    out_d    = 1'b0;
                    ready_d  = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    out_d   = shreg_q[0];
                end
            end
            S_DATA: begin
                if (tick) begin
                    shreg_d = shifted;
                    if (idx_q == IDX_MAX) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = S_PARITY;
                        out_d   = parity_q;
`else
                        state_d = S_STOP;
                        out_d   = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                        out_d = shifted[0];
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                    out_d   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                    out_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                out_d   = 1'b1;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset forces the line high immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shreg_q  <= '0;
            out_q    <= 1'b1;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            out_q    <= out_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign out   = out_q;
    assign ready = ready_q;
    assign busy  = ~ready_q;
    assign done  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: one instance at CLKS_PER_BIT=4 and one at
// CLKS_PER_BIT=1, expected frames written out bit by bit in send order.
module tb_serial_tx;
    localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [15:0] F_A5 = 16'b0_10100101_0_1;
    localparam logic [15:0] F_00 = 16'b0_00000000_0_1;
    localparam logic [15:0] F_FF = 16'b0_11111111_0_1;
    localparam logic [15:0] F_07 = 16'b0_11100000_1_1;
    localparam logic [15:0] F_03 = 16'b0_11000000_0_1;
    localparam logic [15:0] F_3C = 16'b0_00111100_0_1;
    localparam logic [15:0] F_01 = 16'b0_10000000_1_1;
`else
    localparam int NB = 10;
    localparam logic [15:0] F_A5 = 16'b0_10100101_1;
    localparam logic [15:0] F_00 = 16'b0_00000000_1;
    localparam logic [15:0] F_FF = 16'b0_11111111_1;
    localparam logic [15:0] F_07 = 16'b0_11100000_1;
    localparam logic [15:0] F_03 = 16'b0_11000000_1;
    localparam logic [15:0] F_3C = 16'b0_00111100_1;
    localparam logic [15:0] F_01 = 16'b0_10000000_1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data0, data1;
    logic       valid0, valid1;
    logic       ready0, out0, busy0, done0;
    logic       ready1, out1, busy1, done1;
    logic       sel = 1'b0;
    logic       o_out, o_ready, o_busy, o_done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int dc0 = 0;
    int dc1 = 0;
    int hs[$];

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB)) dut0 (
        .clk(clk), .rst_n(rst_n), .data_in(data0), .valid(valid0),
        .ready(ready0), .out(out0), .busy(busy0), .done(done0)
    );

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(data1), .valid(valid1),
        .ready(ready1), .out(out1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    assign o_out   = sel ? out1   : out0;
    assign o_ready = sel ? ready1 : ready0;
    assign o_busy  = sel ? busy1  : busy0;
    assign o_done  = sel ? done1  : done0;

    always @(posedge clk) begin
        if (rst_n && valid0 && ready0) hs.push_back(cyc);
        cyc++;
    end

    always @(negedge clk) begin
        if (done0) dc0++;
        if (done1) dc1++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] d);
        if (sel) begin data1 = d; valid1 = 1'b1; end
        else begin data0 = d; valid0 = 1'b1; end
        step();
    endtask

    // Called one sample after the handshake edge; ends one sample after the done edge.
    task automatic check_frame(input string tag, input logic [15:0] exp,
                               input logic [7:0] mid_data, input bit drop_valid);
        int cpb;
        int frame;
        cpb = sel ? 1 : CPB;
        frame = NB * cpb;
        for (int k = 0; k < frame; k++) begin
            chk($sformatf("%s_out_c%0d", tag, k), 32'(o_out), 32'(exp[NB - 1 - k / cpb]));
            chk($sformatf("%s_bsy_c%0d", tag, k), 32'({o_busy, o_ready, o_done}), 32'(3'b100));
            if (k == frame / 2) begin
                if (sel) data1 = mid_data; else data0 = mid_data;
            end
            step();
        end
        chk({tag, "_end"}, 32'({o_done, o_ready, o_busy, o_out}), 32'(4'b1101));
        if (drop_valid) begin
            if (sel) valid1 = 1'b0; else valid0 = 1'b0;
        end
    endtask

    initial begin
        int n;
        int d_before;
        rst_n = 1'b1;
        valid0 = 1'b0; valid1 = 1'b0;
        data0 = 8'h00; data1 = 8'h00;

        // Reset asserted between edges: outputs settle without a clock.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_dut0", 32'({out0, ready0, busy0, done0}), 32'(4'b1100));
        chk("rst_dut1", 32'({out1, ready1, busy1, done1}), 32'(4'b1100));
        valid0 = 1'b1; valid1 = 1'b1; data0 = 8'h55; data1 = 8'h55;
        step(); step(); step();
        chk("rst_valid_ign0", 32'({out0, ready0, busy0, done0}), 32'(4'b1100));
        chk("rst_valid_ign1", 32'({out1, ready1, busy1, done1}), 32'(4'b1100));
        chk("rst_no_hs", 32'(hs.size()), 32'(0));
        valid0 = 1'b0; valid1 = 1'b0;
        #2 rst_n = 1'b1;
        step();
        chk("idle_after_rst", 32'({out0, ready0, busy0, done0}), 32'(4'b1100));

        // Single frame 0xA5.
        start(8'hA5);
        check_frame("a5", F_A5, 8'h00, 1'b1);
        step();
        chk("a5_idle", 32'({out0, ready0, done0}), 32'(3'b110));

        // Back-to-back with valid held high and data changed mid-frame.
        start(8'h00);
        check_frame("b2b0", F_00, 8'hFF, 1'b0);
        step();
        check_frame("b2b1", F_FF, 8'h5A, 1'b1);
        n = hs.size();
        chk("b2b_spacing", 32'(hs[n-1] - hs[n-2]), 32'(NB * CPB + 1));
        step();

        // Parity-sensitive words (frame includes parity bit when enabled).
        start(8'h07);
        check_frame("w07", F_07, 8'hC3, 1'b1);
        step();
        start(8'h03);
        check_frame("w03", F_03, 8'h81, 1'b1);
        step();

        // Reset during data bit 3 of 0x0F.
        start(8'h0F);
        for (int i = 0; i < 17; i++) step();
        chk("mid_pre_rst", 32'({out0, busy0}), 32'(2'b11));
        d_before = dc0;
        #2 rst_n = 1'b0;
        valid0 = 1'b0;
        #1;
        chk("mid_rst_async", 32'({out0, ready0, busy0, done0}), 32'(4'b1100));
        step(); step();
        chk("mid_rst_hold", 32'({out0, ready0, busy0, done0}), 32'(4'b1100));
        #2 rst_n = 1'b1;
        step();
        chk("mid_rst_after", 32'({out0, ready0, busy0, done0}), 32'(4'b1100));
        chk("mid_rst_nodone", 32'(dc0), 32'(d_before));
        start(8'h3C);
        check_frame("w3c", F_3C, 8'hFF, 1'b1);
        step();

        // CLKS_PER_BIT=1 instance.
        sel = 1'b1;
        start(8'h01);
        check_frame("cpb1", F_01, 8'hAA, 1'b1);
        step();
        chk("cpb1_idle", 32'({out1, ready1, done1}), 32'(3'b110));
        step();
        chk("cpb1_idle2", 32'({out1, ready1, done1}), 32'(3'b110));

        chk("done_count0", 32'(dc0), 32'(6));
        chk("done_count1", 32'(dc1), 32'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
